// File: rtl/regs_status_snap_if.sv
// regs_status_snap_if: read-port handshake and flat read-data bus of the status register window
interface regs_status_snap_if #(
  parameter int C_ADR_W = 4,
  parameter int C_DAT_W = 8
);
  logic                              RD_REQ_i;
  logic [C_ADR_W-1:0]                ADRs_i;
  logic [(2**C_ADR_W)*C_DAT_W-1:0]   RDATss_o;
  logic                              RD_ACK_o;
  modport master (output RD_REQ_i, ADRs_i, input RDATss_o, RD_ACK_o);
  modport slave  (input RD_REQ_i, ADRs_i, output RDATss_o, RD_ACK_o);
endinterface

// File: rtl/regs_status_snap.sv
// regs_status_snap: saturating event counters and sticky flags snapshotted atomically on a read handshake
module regs_status_snap #(
  parameter int C_DAT_W     = 8,
  parameter int C_ADR_W     = 4,
  parameter int C_BASE_ADR  = 10,
  parameter int C_EV_N      = 2,
  parameter int C_CTR_BYTES = 2,
  parameter int C_ACK_DLY   = 2,
  parameter int C_CLR_ON_RD = 1
) (
  input  logic              CK_i,
  input  logic              XARST_i,
  input  logic [C_EV_N-1:0] EV_i,
  input  logic [7:0]        FLAG_i,
  regs_status_snap_if.slave bus
);
  localparam int CW      = 8*C_CTR_BYTES;
  localparam int NS      = 2**C_ADR_W;
  localparam int SEQ_OFS = 1 + C_EV_N*C_CTR_BYTES;
  localparam int DW      = (C_ACK_DLY > 1) ? $clog2(C_ACK_DLY) : 1;
  typedef enum logic [1:0] {IDLE, SNAP, WAIT, DONE} state_t;
  state_t                 r_st;
  logic                   r_req_m, r_req_s, r_ack;
  logic [DW-1:0]          r_dly;
  logic [7:0]             r_flg, r_flg_snp, r_seq;
  logic [CW-1:0]          r_ctr [C_EV_N];
  logic [CW-1:0]          r_snp [C_EV_N];
  logic [NS*C_DAT_W-1:0]  r_rdat, w_rdat;
  logic                   w_snap_flg, w_snap;
  logic [C_EV_N-1:0]      w_snap_ctr;
  if (C_BASE_ADR + SEQ_OFS >= NS || C_ACK_DLY < 1) begin : g_chk
    $error("status window does not fit the address space or ack delay < 1");
  end
  assign w_snap_flg = (r_st == SNAP) && (bus.ADRs_i == C_ADR_W'(C_BASE_ADR));
  for (genvar k = 0; k < C_EV_N; k++) begin : g_hit
    assign w_snap_ctr[k] = (r_st == SNAP) && (bus.ADRs_i == C_ADR_W'(C_BASE_ADR + 1 + k*C_CTR_BYTES));
  end
  assign w_snap = w_snap_flg | (|w_snap_ctr);
  for (genvar n = 0; n < NS; n++) begin : g_slot
    localparam int OFS = n - C_BASE_ADR;
    if (OFS == 0) begin : g_f
      assign w_rdat[n*C_DAT_W +: 8] = r_flg_snp;
    end else if (OFS >= 1 && OFS < SEQ_OFS) begin : g_c
      assign w_rdat[n*C_DAT_W +: 8] = r_snp[(OFS-1)/C_CTR_BYTES][((OFS-1)%C_CTR_BYTES)*8 +: 8];
    end else if (OFS == SEQ_OFS) begin : g_s
      assign w_rdat[n*C_DAT_W +: 8] = r_seq;
    end else begin : g_z
      assign w_rdat[n*C_DAT_W +: 8] = 8'h00;
    end
  end
  assign bus.RDATss_o = r_rdat;
  assign bus.RD_ACK_o = r_ack;
  // request synchronizer and handshake sequencing: one SNAP per request, ack after the delay
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_req_m <= 1'b0;
      r_req_s <= 1'b0;
      r_st    <= IDLE;
      r_ack   <= 1'b1;
      r_dly   <= '0;
    end else begin
      r_req_m <= bus.RD_REQ_i;
      r_req_s <= r_req_m;
      case (r_st)
        IDLE: if (r_req_s) begin
          r_st  <= SNAP;
          r_ack <= 1'b0;
        end
        SNAP: begin
          r_st  <= WAIT;
          r_dly <= '0;
        end
        WAIT: if (r_dly == DW'(C_ACK_DLY-1)) begin
          r_st  <= DONE;
          r_ack <= 1'b1;
        end else r_dly <= r_dly + 1'b1;
        DONE: if (!r_req_s) r_st <= IDLE;
        default: r_st <= IDLE;
      endcase
    end
  end
  // live items, snapshots of the pre-update values, sequence count and registered read bus
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_flg     <= '0;
      r_flg_snp <= '0;
      r_seq     <= '0;
      r_rdat    <= '0;
      for (int k = 0; k < C_EV_N; k++) begin
        r_ctr[k] <= '0;
        r_snp[k] <= '0;
      end
    end else begin
      r_flg  <= ((w_snap_flg && C_CLR_ON_RD != 0) ? 8'h00 : r_flg) | FLAG_i;
      r_rdat <= w_rdat;
      if (w_snap_flg) r_flg_snp <= r_flg;
      if (w_snap) r_seq <= r_seq + 8'd1;
      for (int k = 0; k < C_EV_N; k++) begin
        r_ctr[k] <= (w_snap_ctr[k] && C_CLR_ON_RD != 0) ? CW'(EV_i[k]) : r_ctr[k] + CW'(EV_i[k] && !(&r_ctr[k]));
        if (w_snap_ctr[k]) r_snp[k] <= r_ctr[k];
      end
    end
  end
endmodule
